// File: rtl/mem_port_arbiter.sv
// CPU/DMA single memory port arbiter: round-robin on contention, locked DMA bursts
// capped at MAX_BURST beats when the CPU waits. Define ARB_STATS_EN for stall/transfer counters.
module mem_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
`ifdef ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] cpu_wait_cnt,
  output logic [15:0] dma_xfer_cnt,
`endif
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_CPU = 2'd1;
  localparam logic [1:0] GNT_DMA = 2'd2;

  localparam logic LG_CPU = 1'b0;
  localparam logic LG_DMA = 1'b1;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic       last_grant;
  logic [3:0] beat_cnt, beat_cnt_nxt, beats_now;

  // The granted requester owns the memory port; grants follow the live request
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (state)
      GNT_CPU: begin
        cpu_gnt  = cpu_req;
        mem_we   = cpu_req & cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
      end
      GNT_DMA: begin
        dma_gnt  = dma_req;
        mem_we   = dma_req & dma_we;
        mem_addr = dma_addr;
        mem_wd   = dma_wd;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign beats_now = beat_cnt + {3'b000, dma_req};

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req)
          state_nxt = (last_grant == LG_DMA) ? GNT_CPU : GNT_DMA;
        else if (cpu_req)
          state_nxt = GNT_CPU;
        else if (dma_req)
          state_nxt = GNT_DMA;
        else
          state_nxt = IDLE;
      end
      GNT_CPU: state_nxt = dma_req ? GNT_DMA : IDLE;
      GNT_DMA: begin
        if (!dma_lock) begin
          state_nxt = cpu_req ? GNT_CPU : IDLE;
        end else if (beats_now == BURST_LIMIT) begin
          // Burst cap reached: hand over to a waiting CPU, otherwise start a fresh window
          beat_cnt_nxt = '0;
          if (cpu_req)
            state_nxt = GNT_CPU;
        end else begin
          beat_cnt_nxt = beats_now;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GNT_DMA && state != GNT_DMA)
      beat_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= LG_DMA;
      beat_cnt   <= '0;
      cpu_rd     <= '0;
      dma_rd     <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (cpu_gnt)
        last_grant <= LG_CPU;
      else if (dma_gnt)
        last_grant <= LG_DMA;
      if (cpu_gnt && !cpu_we)
        cpu_rd <= mem_rd;
      if (dma_gnt && !dma_we)
        dma_rd <= mem_rd;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_wait_cnt <= '0;
      dma_xfer_cnt <= '0;
    end else if (stats_clr) begin
      cpu_wait_cnt <= '0;
      dma_xfer_cnt <= '0;
    end else begin
      if (cpu_stall && cpu_wait_cnt != 16'hFFFF)
        cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      if (dma_gnt && dma_xfer_cnt != 16'hFFFF)
        dma_xfer_cnt <= dma_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed CPU/DMA traffic, expected transfers
// queued by the stimulus and popped by a negedge monitor whenever a grant is seen.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWe, cpuGnt, cpuStall;
  logic [31:0] cpuAddr, cpuWd, cpuRd;
  logic        dmaReq, dmaWe, dmaLock, dmaGnt;
  logic [31:0] dmaAddr, dmaWd, dmaRd;
  logic        memWe;
  logic [31:0] memAddr, memWd, memRd;
`ifdef ARB_STATS_EN
  logic        statsClr = 1'b0;
  logic [15:0] cpuWaitCnt, dmaXferCnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isDma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } xfer_t;

  xfer_t expQ[$];

  logic        rdPendCpu = 1'b0, rdPendDma = 1'b0;
  logic [31:0] rdExpCpu = '0, rdExpDma = '0;

  always #5 clk = ~clk;

  // Memory model: one fixed word at 0x40, elsewhere the address xor a marker
  assign memRd = (memAddr == 32'h40) ? 32'hDEADBEEF : (memAddr ^ 32'hA5A5_0000);

  mem_port_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wd(cpuWd),
    .cpu_gnt(cpuGnt), .cpu_rd(cpuRd), .cpu_stall(cpuStall),
    .dma_req(dmaReq), .dma_we(dmaWe), .dma_lock(dmaLock),
    .dma_addr(dmaAddr), .dma_wd(dmaWd), .dma_gnt(dmaGnt), .dma_rd(dmaRd),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wd(memWd),
`ifdef ARB_STATS_EN
    .stats_clr(statsClr), .cpu_wait_cnt(cpuWaitCnt), .dma_xfer_cnt(dmaXferCnt),
`endif
    .mem_rd(memRd)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                               input bit dr, input bit dw, input bit dl, input logic [31:0] da,
                               input logic [31:0] dd);
    cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWd = cd;
    dmaReq = dr; dmaWe = dw; dmaLock = dl; dmaAddr = da; dmaWd = dd;
  endtask

  task automatic expectXfer(input bit isDma, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd);
    xfer_t e;
    e.isDma = isDma; e.we = we; e.addr = addr; e.wd = wd; e.rd = rd;
    expQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    checkOutput("rst_cpu_gnt", cpuGnt, 0);
    checkOutput("rst_dma_gnt", dmaGnt, 0);
    checkOutput("rst_mem_we", memWe, 0);
    checkOutput("rst_mem_addr", memAddr, 0);
    checkOutput("rst_cpu_rd", cpuRd, 0);
    checkOutput("rst_dma_rd", dmaRd, 0);
    nextCycle();
    reset = 1'b1;
  endtask

  // Monitor: every grant must match the next queued transfer; read data checked one cycle later
  always @(negedge clk) begin
    if (reset) begin
      if (rdPendCpu) checkOutput("sb_cpu_rd", cpuRd, rdExpCpu);
      if (rdPendDma) checkOutput("sb_dma_rd", dmaRd, rdExpDma);
      rdPendCpu <= 1'b0;
      rdPendDma <= 1'b0;
      if (cpuGnt || dmaGnt) begin
        checkOutput("sb_single_gnt", cpuGnt & dmaGnt, 0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got grant cpu=%b dma=%b, expected none at %0t", cpuGnt, dmaGnt, $time);
        end else begin
          xfer_t e;
          e = expQ.pop_front();
          checkOutput("sb_who", dmaGnt, e.isDma);
          checkOutput("sb_we", memWe, e.we);
          checkOutput("sb_addr", memAddr, e.addr);
          if (e.we)
            checkOutput("sb_wd", memWd, e.wd);
          else if (e.isDma) begin
            rdPendDma <= 1'b1;
            rdExpDma  <= e.rd;
          end else begin
            rdPendCpu <= 1'b1;
            rdExpCpu  <= e.rd;
          end
        end
      end else begin
        checkOutput("sb_idle_we", memWe, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of run, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stallSeen;
    int dmaBeats;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    doReset();

    // CPU read alone
    applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    expectXfer(0, 0, 32'h40, 0, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_c0_gnt", cpuGnt, 0);
    checkOutput("t1_c0_stall", cpuStall, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_c1_gnt", cpuGnt, 1);
    checkOutput("t1_c1_stall", cpuStall, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_c2_rd", cpuRd, 32'hDEADBEEF);
    checkOutput("t1_c2_gnt", cpuGnt, 0);
    nextCycle();

    // Contention out of reset: CPU first, then DMA, then idle
    doReset();
    applyStimulus(1, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0);
    expectXfer(0, 0, 32'h100, 0, 32'hA5A50100);
    expectXfer(1, 0, 32'h200, 0, 32'hA5A50200);
    @(negedge clk);
    checkOutput("t2_c0_any", cpuGnt | dmaGnt, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_c1_cpu", cpuGnt, 1);
    checkOutput("t2_c1_dma", dmaGnt, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h200, 0);
    @(negedge clk);
    checkOutput("t2_c2_dma", dmaGnt, 1);
    checkOutput("t2_c2_cpu", cpuGnt, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2_c3_idle", cpuGnt | dmaGnt, 0);
    nextCycle();

    // Single DMA write
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h80, 32'h1234);
    expectXfer(1, 1, 32'h80, 32'h1234, 0);
    @(negedge clk);
    checkOutput("t3_c0_we", memWe, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_c1_we", memWe, 1);
    checkOutput("t3_c1_wd", memWd, 32'h1234);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_c2_we", memWe, 0);
    checkOutput("t3_c2_dma_rd_held", dmaRd, 32'hA5A50200);
    nextCycle();

    // Locked DMA burst with CPU waiting from the first beat
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h300, 0);
    for (int k = 0; k < 4; k++)
      expectXfer(1, 1, 32'h300 + 32'(4 * k), 32'(k), 0);
    expectXfer(0, 0, 32'h500, 0, 32'hA5A50500);
    expectXfer(1, 1, 32'h310, 32'h4, 0);
    @(negedge clk);
    checkOutput("t4_c0_dma", dmaGnt, 0);
    nextCycle();
    stallSeen = 0;
    dmaBeats  = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 32'h500, 0, 1, 1, 1, 32'h300 + 32'(4 * (k - 1)), 32'(k - 1));
      @(negedge clk);
      if (cpuStall) stallSeen++;
      if (dmaGnt) dmaBeats++;
      nextCycle();
    end
    checkOutput("t4_stall_cycles", stallSeen, 4);
    checkOutput("t4_dma_beats", dmaBeats, 4);
    applyStimulus(1, 0, 32'h500, 0, 1, 1, 1, 32'h310, 32'h4);
    @(negedge clk);
    checkOutput("t4_c5_cpu", cpuGnt, 1);
    checkOutput("t4_c5_dma", dmaGnt, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h310, 32'h4);
    @(negedge clk);
    checkOutput("t4_c6_dma", dmaGnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4_c7_dma", dmaGnt, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_c8_idle", cpuGnt | dmaGnt, 0);
    nextCycle();

    // CPU write so the CPU holds last grant before the reset test
    applyStimulus(1, 1, 32'h800, 32'h88, 0, 0, 0, 0, 0);
    expectXfer(0, 1, 32'h800, 32'h88, 0);
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_cpu_we", memWe, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5_cpu_rd_held", cpuRd, 32'hA5A50500);
    nextCycle();

    // Reset in the middle of a DMA write grant
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h600, 32'h66);
    @(negedge clk);
    nextCycle();
    checkOutput("t6_pre_gnt", dmaGnt, 1);
    checkOutput("t6_pre_we", memWe, 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_we", memWe, 0);
    checkOutput("t6_rst_gnt", dmaGnt, 0);
    checkOutput("t6_rst_dma_rd", dmaRd, 0);
    checkOutput("t6_rst_cpu_rd", cpuRd, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1, 0, 32'h700, 0, 1, 0, 0, 32'h710, 0);
    expectXfer(0, 0, 32'h700, 0, 32'hA5A50700);
    expectXfer(1, 0, 32'h710, 0, 32'hA5A50710);
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("t6_cpu_first", cpuGnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h710, 0);
    @(negedge clk);
    checkOutput("t6_dma_second", dmaGnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nextCycle();

`ifdef ARB_STATS_EN
    // Three CPU stall cycles during a locked burst, then a clear
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h900, 0);
    for (int k = 0; k < 4; k++)
      expectXfer(1, 1, 32'h900 + 32'(4 * k), 32'(k), 0);
    expectXfer(0, 0, 32'h40, 0, 32'hDEADBEEF);
    @(negedge clk);
    nextCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(k >= 2, 0, 32'h40, 0, 1, 1, 1, 32'h900 + 32'(4 * (k - 1)), 32'(k - 1));
      @(negedge clk);
      nextCycle();
    end
    applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("st_cpu_gnt", cpuGnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    statsClr = 1'b1;
    @(negedge clk);
    checkOutput("st_wait_cnt", cpuWaitCnt, 3);
    checkOutput("st_xfer_cnt", dmaXferCnt, 4);
    nextCycle();
    statsClr = 1'b0;
    @(negedge clk);
    checkOutput("st_wait_clr", cpuWaitCnt, 0);
    checkOutput("st_xfer_clr", dmaXferCnt, 0);
    nextCycle();
`endif

    checkOutput("sb_queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum locked DMA beats before a waiting CPU is forced in (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_req, cpu_we  input  1 each  CPU transfer request; write qualifier.
REQ-005 cpu_addr, cpu_wd  input  32 each  CPU address; write data.
REQ-006 cpu_gnt  output  1  CPU transfer performed this cycle.
REQ-007 cpu_rd  output  32  CPU read data, registered.
REQ-008 cpu_stall  output  1  cpu_req & ~cpu_gnt, for gating PC/IR enables.
REQ-009 dma_req, dma_we, dma_lock  input  1 each  DMA request; write qualifier; burst lock.
REQ-010 dma_addr, dma_wd  input  32 each  DMA address; write data.
REQ-011 dma_gnt  output  1  DMA transfer performed this cycle.
REQ-012 dma_rd  output  32  DMA read data, registered.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr, mem_wd  output  32 each  memory address; write data.
REQ-015 mem_rd  input  32  memory read data, combinational from mem_addr.

Function
REQ-016 FSM states IDLE, GNT_CPU, GNT_DMA, held in a state register; a 1-bit last_grant register records the most recently granted requester.
REQ-017 In IDLE: cpu_gnt=dma_gnt=0, mem_we=0, mem_addr=0, mem_wd=0.
REQ-018 In GNT_x: mem_addr/mem_wd driven from requester x; mem_we = x_req & x_we; x_gnt = x_req (combinational).
REQ-019 A transfer occurs in any cycle with x_req & x_gnt; a requester holds req, we, addr, wd stable until it sees gnt.
REQ-020 On a transfer cycle with x_we=0, x_rd captures mem_rd at that clock edge; valid from the next cycle; held until the next read transfer of x.
REQ-021 Latency: req rises in an IDLE cycle N -> gnt in cycle N+1 -> read data valid in cycle N+2.
REQ-022 From IDLE: a single request -> that requester's GNT state; both requesting -> grant the requester that is not last_grant (round-robin).
REQ-023 From GNT_CPU: dma_req=1 -> GNT_DMA; otherwise -> IDLE. Each CPU grant is exactly one cycle.
REQ-024 From GNT_DMA with dma_lock=0: cpu_req=1 -> GNT_CPU; otherwise -> IDLE.
REQ-025 From GNT_DMA with dma_lock=1: remain in GNT_DMA, counting beats (cycles with dma_req=1) in a 4-bit counter.
REQ-026 When beat count reaches MAX_BURST and cpu_req=1 -> GNT_CPU, counter cleared; if cpu_req=0, the counter clears and the lock continues.
REQ-027 Cycles with dma_req=0 inside a locked grant are not counted, and mem_we=0 in those cycles.
REQ-028 The beat counter clears on every entry to GNT_DMA.
REQ-029 last_grant updates on every transfer cycle.
REQ-030 A request that drops before being granted is discarded without a transfer and without error.

Reset
REQ-031 reset=0 forces, asynchronously: state=IDLE, last_grant=DMA (CPU wins the first contention), beat counter=0, cpu_rd=dma_rd=0, all gnt outputs and mem_we=0.
REQ-032 Reset asserted mid-transfer aborts it; no write is issued in the reset cycle.

Configuration
REQ-033 Macro ARB_STATS_EN defined: add outputs cpu_wait_cnt[15:0] and dma_xfer_cnt[15:0]. cpu_wait_cnt increments on each cpu_stall=1 cycle; dma_xfer_cnt increments on each DMA transfer; both saturate at 16'hFFFF; both reset to 0; both clear synchronously on input stats_clr.
REQ-034 Macro ARB_STATS_EN undefined: these ports, stats_clr and the counters are absent; all other behaviour is identical.

Verification
REQ-035 CPU read alone: cpu_addr=0x40 requested in cycle 0 with mem_rd=0xDEADBEEF -> cpu_gnt=1 in cycle 1, cpu_rd=0xDEADBEEF from cycle 2, mem_we=0 throughout.
REQ-036 Simultaneous cpu_req and dma_req out of reset -> CPU granted first, then DMA on the following cycle; then IDLE.
REQ-037 DMA locked burst, MAX_BURST=4, cpu_req held high -> four consecutive dma_gnt cycles, then cpu_gnt=1; cpu_stall=1 for the 4 preceding cycles.
REQ-038 DMA write of 0x1234 to 0x80 -> mem_we=1, mem_addr=0x80, mem_wd=0x1234 for exactly one cycle.
REQ-039 reset asserted during GNT_DMA with dma_we=1 -> mem_we=0 immediately, state=IDLE, and the next contention is won by the CPU.
REQ-040 ARB_STATS_EN defined, 3 CPU stall cycles then stats_clr -> cpu_wait_cnt reads 3, then 0 on the cycle after the clear.
